cycle_counter_mmio: RTL



---
 rtl/cycle_counter_mmio.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/cycle_counter_mmio.sv
// Memory-mapped control front-end for the cycle counter: CTRL/CYCLES/STATUS/READOUT registers.
// Optional completion interrupt is built when CYCLE_COUNTER_MMIO_IRQ_EN is defined.
module cycle_counter_mmio #(
  parameter int COUNT_WIDTH   = 32,
  parameter bit BASE_SEL_ONLY = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   sel_i,
  input  logic                   we_i,
  input  logic [3:0]             addr_i,
  input  logic [31:0]            wdata_i,
  output logic [31:0]            rdata_o,
  output logic                   ack_o,
  output logic [COUNT_WIDTH-1:0] cycles_o,
  output logic                   start_o,
  output logic                   enable_o,
  input  logic [COUNT_WIDTH-1:0] readout_i,
  output logic                   irq_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_CYCLES  = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_READOUT = 2'd3;

  localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = {COUNT_WIDTH{1'b0}};
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]             state_r, state_nx_s;
  logic [COUNT_WIDTH-1:0] cycles_r, cycles_nx_s;
  logic [COUNT_WIDTH-1:0] remaining_r, remaining_nx_s;
  logic [COUNT_WIDTH-1:0] capture_r, capture_nx_s;
  logic                   enable_r, enable_nx_s;
  logic                   irq_en_r, irq_en_nx_s;
  logic                   done_r, done_nx_s;
  logic                   reject_r, reject_nx_s;
  logic                   start_r, start_nx_s;
  logic                   irq_r, irq_nx_s;
  logic                   ack_r;
  logic [31:0]            rdata_r, rdata_nx_s;
  logic                   mapped_s, wr_ctrl_s, wr_cycles_s, start_req_s, clr_req_s;

  // With external chip select the low address bits are don't-care.
  assign mapped_s    = BASE_SEL_ONLY ? 1'b1 : (addr_i[1:0] == 2'b00);
  assign wr_ctrl_s   = sel_i & we_i & mapped_s & (addr_i[3:2] == REG_CTRL);
  assign wr_cycles_s = sel_i & we_i & mapped_s & (addr_i[3:2] == REG_CYCLES);
  assign start_req_s = wr_ctrl_s & wdata_i[0];
  assign clr_req_s   = wr_ctrl_s & wdata_i[2];

  // Next-state logic for the run FSM, control registers and status flags.
  always_comb begin
    state_nx_s     = state_r;
    cycles_nx_s    = cycles_r;
    remaining_nx_s = remaining_r;
    capture_nx_s   = capture_r;
    enable_nx_s    = enable_r;
    irq_en_nx_s    = irq_en_r;
    done_nx_s      = done_r;
    reject_nx_s    = reject_r;
    start_nx_s     = 1'b0;

    if (wr_ctrl_s) begin
      enable_nx_s = wdata_i[1];
`ifdef CYCLE_COUNTER_MMIO_IRQ_EN
      irq_en_nx_s = wdata_i[3];
`else
      irq_en_nx_s = 1'b0;
`endif
    end else begin
      enable_nx_s = enable_r;
    end

    // The target is frozen for the whole run so cycles_o stays stable.
    if (wr_cycles_s && (state_r != ST_RUN)) begin
      cycles_nx_s = wdata_i[COUNT_WIDTH-1:0];
    end else begin
      cycles_nx_s = cycles_r;
    end

    case (state_r)
      ST_IDLE, ST_DONE: begin
        // Clear is applied before start so CLR_DONE|START re-arms from DONE.
        if (clr_req_s) begin
          done_nx_s   = 1'b0;
          reject_nx_s = 1'b0;
          state_nx_s  = ST_IDLE;
        end else begin
          state_nx_s  = state_r;
        end
        if (start_req_s) begin
          if (cycles_r != CNT_ZERO) begin
            start_nx_s     = 1'b1;
            remaining_nx_s = cycles_r;
            done_nx_s      = 1'b0;
            state_nx_s     = ST_RUN;
          end else begin
            reject_nx_s    = 1'b1;
          end
        end else begin
          start_nx_s = 1'b0;
        end
      end
      ST_RUN: begin
        if (clr_req_s) begin
          reject_nx_s = 1'b0;
        end else begin
          reject_nx_s = reject_r;
        end
        if (start_req_s) begin
          reject_nx_s = 1'b1;
        end else begin
          start_nx_s  = 1'b0;
        end
        if (enable_r && (remaining_r != CNT_ZERO)) begin
          remaining_nx_s = remaining_r - CNT_ONE;
          if (remaining_r == CNT_ONE) begin
            state_nx_s   = ST_DONE;
            done_nx_s    = 1'b1;
            capture_nx_s = readout_i;
          end else begin
            state_nx_s   = ST_RUN;
          end
        end else begin
          remaining_nx_s = remaining_r;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Read mux samples register contents as they stand in the request cycle.
  always_comb begin
    rdata_nx_s = 32'd0;
    if (sel_i && !we_i && mapped_s) begin
      case (addr_i[3:2])
        REG_CTRL:    rdata_nx_s = {28'd0, irq_en_r, 1'b0, enable_r, 1'b0};
        REG_CYCLES:  rdata_nx_s[COUNT_WIDTH-1:0] = cycles_r;
        REG_STATUS:  rdata_nx_s = {29'd0, reject_r, done_r, (state_r == ST_RUN)};
        REG_READOUT: rdata_nx_s[COUNT_WIDTH-1:0] = (state_r == ST_RUN) ? readout_i : capture_r;
        default:     rdata_nx_s = 32'd0;
      endcase
    end else begin
      rdata_nx_s = 32'd0;
    end
  end

  // Interrupt level follows DONE one cycle late.
  always_comb begin
`ifdef CYCLE_COUNTER_MMIO_IRQ_EN
    irq_nx_s = done_r & irq_en_r;
`else
    irq_nx_s = 1'b0;
`endif
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r     <= ST_IDLE;
      cycles_r    <= CNT_ZERO;
      remaining_r <= CNT_ZERO;
      capture_r   <= CNT_ZERO;
      enable_r    <= 1'b0;
      irq_en_r    <= 1'b0;
      done_r      <= 1'b0;
      reject_r    <= 1'b0;
      start_r     <= 1'b0;
      irq_r       <= 1'b0;
      ack_r       <= 1'b0;
      rdata_r     <= 32'd0;
    end else begin
      state_r     <= state_nx_s;
      cycles_r    <= cycles_nx_s;
      remaining_r <= remaining_nx_s;
      capture_r   <= capture_nx_s;
      enable_r    <= enable_nx_s;
      irq_en_r    <= irq_en_nx_s;
      done_r      <= done_nx_s;
      reject_r    <= reject_nx_s;
      start_r     <= start_nx_s;
      irq_r       <= irq_nx_s;
      ack_r       <= sel_i;
      rdata_r     <= rdata_nx_s;
    end
  end

  assign rdata_o  = rdata_r;
  assign ack_o    = ack_r;
  assign cycles_o = cycles_r;
  assign start_o  = start_r;
  assign enable_o = enable_r;
  assign irq_o    = irq_r;

endmodule
